chunked_adder_flags: RTL

Multi-cycle, parametrised add/subtract unit that processes WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between chunks, and reports Zero, Carry/Borrow, Sign, Parity and Overflow flags. It is the parametrised, handshaked successor to the team's fixed 16-bit, 4-bit-slice ripple adder. It trades latency for a short carry chain and sits behind a valid/ready interface so datapath controllers can stall on it.

---
 rtl/chunked_adder_pkg.sv | 29 ++
 rtl/chunked_adder_flags_slice.sv | 24 ++
 rtl/chunked_adder_flags.sv | 138 +++++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM states, flag
// vector layout and chunk-count sizing helpers.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CF     = 0;
    localparam int unsigned ZF     = 1;
    localparam int unsigned SF     = 2;
    localparam int unsigned PF     = 3;
    localparam int unsigned OF     = 4;
    localparam int unsigned NFLAGS = 5;

    function automatic int unsigned nchunk_f(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Counter must be at least one bit wide even when there is a single chunk.
    function automatic int unsigned cnt_width_f(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_adder_flags_slice.sv
// Combinational CHUNK-bit ripple-carry adder used once per cycle by the
// chunked add/subtract unit.
module adder_slice #(
    parameter int unsigned CHUNK = 4
) (
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    input  logic             cin,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/chunked_adder_flags.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per clock with a
// registered carry between chunks, valid/ready handshakes and ALU flags.
module chunked_adder_flags
    import chunked_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cflag,
    output logic             zero,
    output logic             sign,
    output logic             parity,
    output logic             overflow
);

    localparam int unsigned      NCHUNK     = nchunk_f(WIDTH, CHUNK);
    localparam int unsigned      CW         = cnt_width_f(WIDTH, CHUNK);
    localparam logic [CW-1:0]    K_LAST     = CW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    beff_q, beff_d;
    logic [WIDTH-1:0]    s_q, s_d;
    logic                sub_q, sub_d;
    logic                carry_q, carry_d;
    logic [CW-1:0]       k_q, k_d;
    logic [NFLAGS-1:0]   flags_q, flags_d;

    logic [CHUNK-1:0]    a_chunk, b_chunk, sum_chunk;
    logic                cout_chunk;
    logic [WIDTH-1:0]    s_new;
    int unsigned         lsb;

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .sum  (sum_chunk),
        .cout (cout_chunk),
        .cin  (carry_q),
        .a    (a_chunk),
        .b    (b_chunk)
    );

    // Chunk selection by shifting keeps the carry path to one CHUNK slice.
    always_comb begin
        lsb     = 32'(k_q) * CHUNK;
        a_chunk = CHUNK'(a_q >> lsb);
        b_chunk = CHUNK'(beff_q >> lsb);
        s_new   = (s_q & ~(CHUNK_MASK << lsb)) | (WIDTH'(sum_chunk) << lsb);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        beff_d  = beff_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        k_d     = k_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    beff_d  = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    sub_d   = sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d     = s_new;
                carry_d = cout_chunk;
                if (k_q == K_LAST) begin
                    flags_d[CF] = sub_q ^ cout_chunk;
                    flags_d[ZF] = ~|s_new;
                    flags_d[SF] = s_new[WIDTH-1];
                    flags_d[PF] = ~^s_new;
                    flags_d[OF] = (a_q[WIDTH-1] ^ s_new[WIDTH-1]) &
                                  (beff_q[WIDTH-1] ^ s_new[WIDTH-1]);
                    state_d     = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            beff_q  <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            beff_q  <= beff_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cflag     = flags_q[CF];
    assign zero      = flags_q[ZF];
    assign sign      = flags_q[SF];
    assign parity    = flags_q[PF];
    assign overflow  = flags_q[OF];

endmodule
